// File: rtl/cga_wrf_wr_ctrl.sv
// Write-port controller for the 16-entry working register file: request FIFO,
// one-write-per-cycle drain onto RB_15_0/WR_15_0, and pending-write forwarding.
module cga_wrf_wr_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        ALUCLK,
  input  logic        RESET,
  input  logic        WREQ,
  input  logic [3:0]  WADDR,
  input  logic [15:0] WDATA,
  output logic        READY,
  input  logic        HOLD,
  output logic [15:0] RB_15_0,
  output logic [15:0] WR_15_0,
  input  logic [3:0]  RADDR,
  output logic        BYP_HIT,
  output logic [15:0] BYP_DATA,
  output logic        PEND
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [3:0]       mem_addr [DEPTH];
  logic [15:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // A full FIFO refuses requests even when it drains on the same edge.
  assign READY = (count != CNT_W'(DEPTH));
  assign push  = WREQ & READY;
  assign pop   = (count != '0) & ~HOLD;
  assign PEND  = (count != '0) | (WR_15_0 != '0);

  always_ff @(posedge ALUCLK) begin
    if (push) begin
      mem_addr[wr_ptr] <= WADDR;
      mem_data[wr_ptr] <= WDATA;
    end
  end

  always_ff @(posedge ALUCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      WR_15_0 <= '0;
      RB_15_0 <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        WR_15_0 <= 16'(1) << mem_addr[rd_ptr];
        RB_15_0 <= mem_data[rd_ptr];
      end else begin
        WR_15_0 <= '0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to newest so the youngest matching entry is the one left standing;
  // the output stage is older than anything still in the FIFO.
  always_comb begin
    logic [PTR_W-1:0] idx;
    BYP_HIT  = 1'b0;
    BYP_DATA = '0;
    idx      = rd_ptr;
    if (WR_15_0[RADDR]) begin
      BYP_HIT  = 1'b1;
      BYP_DATA = RB_15_0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem_addr[idx] == RADDR)) begin
        BYP_HIT  = 1'b1;
        BYP_DATA = mem_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_cga_wrf_wr_ctrl.sv
// Bench for cga_wrf_wr_ctrl: hand-computed vector table, forwarding and reset
// sequences, and a queue-based scoreboard for sustained and random traffic.
module tb_cga_wrf_wr_ctrl;
  localparam int DEPTH = 2;

  logic        ALUCLK = 1'b0;
  logic        RESET;
  logic        WREQ;
  logic [3:0]  WADDR;
  logic [15:0] WDATA;
  logic        READY;
  logic        HOLD;
  logic [15:0] RB_15_0;
  logic [15:0] WR_15_0;
  logic [3:0]  RADDR;
  logic        BYP_HIT;
  logic [15:0] BYP_DATA;
  logic        PEND;

  int nvec = 0;
  int nerr = 0;
  int ndut_strobes = 0;

  cga_wrf_wr_ctrl #(.DEPTH(DEPTH)) dut (
    .ALUCLK(ALUCLK), .RESET(RESET), .WREQ(WREQ), .WADDR(WADDR), .WDATA(WDATA),
    .READY(READY), .HOLD(HOLD), .RB_15_0(RB_15_0), .WR_15_0(WR_15_0),
    .RADDR(RADDR), .BYP_HIT(BYP_HIT), .BYP_DATA(BYP_DATA), .PEND(PEND)
  );

  always #5 ALUCLK = ~ALUCLK;

  typedef struct {
    logic        wreq;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        hold;
    logic [3:0]  raddr;
    logic        ready;  // before the edge
    logic        hit;    // before the edge
    logic [15:0] bdata;  // before the edge
    logic [15:0] wr;     // after the edge
    logic [15:0] rb;     // after the edge
    logic        pend;   // after the edge
  } vec_t;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  vec_t        tbl [11];
  ent_t        mf[$];
  logic [15:0] exp_wr;
  logic [15:0] exp_rb;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wreq, input logic [3:0] waddr, input logic [15:0] wdata,
                       input logic hold, input logic [3:0] raddr);
    @(negedge ALUCLK);
    WREQ = wreq; WADDR = waddr; WDATA = wdata; HOLD = hold; RADDR = raddr;
    #1;
  endtask

  task automatic tick();
    @(posedge ALUCLK);
    #1;
    if (WR_15_0 != 16'h0) ndut_strobes++;
  endtask

  task automatic do_reset();
    @(negedge ALUCLK);
    RESET = 1'b1; WREQ = 1'b0; HOLD = 1'b0; WADDR = 4'h0; WDATA = 16'h0; RADDR = 4'h0;
    @(negedge ALUCLK);
    RESET = 1'b0;
    mf.delete();
    exp_wr = 16'h0;
    exp_rb = 16'h0;
  endtask

  // Scoreboard step: entries queue at acceptance and are popped when the DUT should drain them.
  task automatic sb_step(input logic wreq, input logic [3:0] waddr, input logic [15:0] wdata,
                         input logic hold, input logic [3:0] raddr);
    logic        ehit;
    logic [15:0] edata;
    logic        acc;
    ent_t        e;
    drive(wreq, waddr, wdata, hold, raddr);
    ehit  = 1'b0;
    edata = 16'h0;
    if (exp_wr[raddr]) begin
      ehit  = 1'b1;
      edata = exp_rb;
    end
    foreach (mf[i]) begin
      if (mf[i].a == raddr) begin
        ehit  = 1'b1;
        edata = mf[i].d;
      end
    end
    chk("sb_ready", {15'h0, READY}, {15'h0, mf.size() < DEPTH});
    chk("sb_byp_hit", {15'h0, BYP_HIT}, {15'h0, ehit});
    chk("sb_byp_data", BYP_DATA, edata);
    acc = wreq && (mf.size() < DEPTH);
    if (!hold && mf.size() > 0) begin
      e      = mf.pop_front();
      exp_wr = 16'(1) << e.a;
      exp_rb = e.d;
    end else begin
      exp_wr = 16'h0;
    end
    if (acc) begin
      e.a = waddr;
      e.d = wdata;
      mf.push_back(e);
    end
    tick();
    chk("sb_wr", WR_15_0, exp_wr);
    chk("sb_rb", RB_15_0, exp_rb);
    chk("sb_pend", {15'h0, PEND}, {15'h0, (mf.size() > 0) || (exp_wr != 16'h0)});
    if (WR_15_0 != 16'h0) chk("sb_onehot", {15'h0, $onehot(WR_15_0)}, 16'h1);
  endtask

  initial begin
    RESET = 1'b1; WREQ = 1'b0; HOLD = 1'b0; WADDR = 4'h0; WDATA = 16'h0; RADDR = 4'h0;
    exp_wr = 16'h0; exp_rb = 16'h0;

    // single write to r5, then HOLD with three requests to r1..r3
    tbl[0]  = '{1'b1, 4'd5, 16'hA5C3, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 1'b1, 1'b1, 16'hA5C3, 16'h0020, 16'hA5C3, 1'b1};
    tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 1'b1, 1'b1, 16'hA5C3, 16'h0000, 16'hA5C3, 1'b0};
    tbl[3]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd5, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA5C3, 1'b1};
    tbl[4]  = '{1'b1, 4'd2, 16'h2222, 1'b1, 4'd1, 1'b1, 1'b1, 16'h1111, 16'h0000, 16'hA5C3, 1'b1};
    tbl[5]  = '{1'b1, 4'd3, 16'h3333, 1'b1, 4'd2, 1'b0, 1'b1, 16'h2222, 16'h0000, 16'hA5C3, 1'b1};
    tbl[6]  = '{1'b1, 4'd3, 16'h3333, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5C3, 1'b1};
    tbl[7]  = '{1'b1, 4'd3, 16'h3333, 1'b0, 4'd1, 1'b0, 1'b1, 16'h1111, 16'h0002, 16'h1111, 1'b1};
    tbl[8]  = '{1'b1, 4'd3, 16'h3333, 1'b0, 4'd1, 1'b1, 1'b1, 16'h1111, 16'h0004, 16'h2222, 1'b1};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 16'h3333, 16'h0008, 16'h3333, 1'b1};
    tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b1, 16'h3333, 16'h0000, 16'h3333, 1'b0};

    #2;
    chk("rst_ready", {15'h0, READY}, 16'h1);
    chk("rst_pend", {15'h0, PEND}, 16'h0);
    chk("rst_wr", WR_15_0, 16'h0);
    chk("rst_rb", RB_15_0, 16'h0);
    chk("rst_byp_hit", {15'h0, BYP_HIT}, 16'h0);
    chk("rst_byp_data", BYP_DATA, 16'h0);
    @(negedge ALUCLK);
    RESET = 1'b0;

    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].wreq, tbl[k].waddr, tbl[k].wdata, tbl[k].hold, tbl[k].raddr);
      chk($sformatf("tbl%0d_ready", k), {15'h0, READY}, {15'h0, tbl[k].ready});
      chk($sformatf("tbl%0d_hit", k), {15'h0, BYP_HIT}, {15'h0, tbl[k].hit});
      chk($sformatf("tbl%0d_bdata", k), BYP_DATA, tbl[k].bdata);
      tick();
      chk($sformatf("tbl%0d_wr", k), WR_15_0, tbl[k].wr);
      chk($sformatf("tbl%0d_rb", k), RB_15_0, tbl[k].rb);
      chk($sformatf("tbl%0d_pend", k), {15'h0, PEND}, {15'h0, tbl[k].pend});
    end

    // forwarding: two pending writes to r7, youngest wins, no merging on drain
    do_reset();
    drive(1'b1, 4'd7, 16'h1234, 1'b1, 4'd7);
    chk("fwd_empty_hit", {15'h0, BYP_HIT}, 16'h0);
    tick();
    drive(1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd7);
    chk("fwd_one_data", BYP_DATA, 16'h1234);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    chk("fwd_full_ready", {15'h0, READY}, 16'h0);
    chk("fwd_r7_hit", {15'h0, BYP_HIT}, 16'h1);
    chk("fwd_r7_data", BYP_DATA, 16'hBEEF);
    RADDR = 4'd6;
    #1;
    chk("fwd_r6_hit", {15'h0, BYP_HIT}, 16'h0);
    chk("fwd_r6_data", BYP_DATA, 16'h0);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd7);
    tick();
    chk("fwd_drain1_wr", WR_15_0, 16'h0080);
    chk("fwd_drain1_rb", RB_15_0, 16'h1234);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd7);
    chk("fwd_fifo_over_out", BYP_DATA, 16'hBEEF);
    tick();
    chk("fwd_drain2_wr", WR_15_0, 16'h0080);
    chk("fwd_drain2_rb", RB_15_0, 16'hBEEF);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd7);
    chk("fwd_out_only", BYP_DATA, 16'hBEEF);
    tick();
    chk("fwd_done_wr", WR_15_0, 16'h0);
    chk("fwd_done_hit", {15'h0, BYP_HIT}, 16'h0);
    chk("fwd_done_pend", {15'h0, PEND}, 16'h0);

    // sustained traffic: 20 back-to-back writes, addresses wrapping
    do_reset();
    ndut_strobes = 0;
    for (int i = 0; i < 20; i++) begin
      sb_step(1'b1, 4'(i % 16), 16'(16'h5000 + i * 16'h0101), 1'b0, 4'(i % 16));
      chk("cont_ready_kept", {15'h0, READY}, 16'h1);
    end
    for (int i = 0; i < 3; i++) sb_step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("cont_strobe_count", 16'(ndut_strobes), 16'd20);
    chk("cont_sb_empty", 16'(mf.size()), 16'd0);

    // random traffic with HOLD, small address range for frequent forwarding hits
    for (int i = 0; i < 60; i++)
      sb_step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
              ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)));

    // reset while a strobe is active and an entry is pending
    do_reset();
    drive(1'b1, 4'd9, 16'h9999, 1'b0, 4'd10);
    tick();
    drive(1'b1, 4'd10, 16'hAAAA, 1'b0, 4'd10);
    tick();
    chk("rs_pre_wr", WR_15_0, 16'h0200);
    RESET = 1'b1;
    WREQ  = 1'b0;
    #1;
    chk("rs_wr_async", WR_15_0, 16'h0);
    chk("rs_ready", {15'h0, READY}, 16'h1);
    chk("rs_pend", {15'h0, PEND}, 16'h0);
    chk("rs_hit", {15'h0, BYP_HIT}, 16'h0);
    chk("rs_data", BYP_DATA, 16'h0);
    @(negedge ALUCLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd10);
      tick();
      chk("rs_no_strobe", WR_15_0, 16'h0);
    end

    // reset while the FIFO is full under HOLD
    drive(1'b1, 4'd1, 16'h0101, 1'b1, 4'd1);
    tick();
    drive(1'b1, 4'd2, 16'h0202, 1'b1, 4'd1);
    tick();
    chk("rf_full_ready", {15'h0, READY}, 16'h0);
    RESET = 1'b1;
    WREQ  = 1'b0;
    HOLD  = 1'b0;
    #1;
    chk("rf_ready", {15'h0, READY}, 16'h1);
    chk("rf_pend", {15'h0, PEND}, 16'h0);
    @(negedge ALUCLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd1);
      tick();
      chk("rf_no_strobe", WR_15_0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cga_wrf_wr_ctrl.md
# cga_wrf_wr_ctrl

Write-port controller for the 16-entry working register file. It sits directly upstream of the per-register 16-bit storage blocks. It accepts register-write requests (address + data) from the ALU result path and buffers them in a small FIFO. It then drains the FIFO one write per cycle, driving the shared write bus RB_15_0 and a one-hot write-enable strobe per register. A read-side forwarding port lets the operand path see data that is still pending in the controller.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2.
- ALUCLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WREQ  in  1  write request valid.
- WADDR  in  4  target register index.
- WDATA  in  16  write data.
- READY  out  1  FIFO not full; a request is accepted when WREQ & READY at an edge.
- HOLD  in  1  freeze draining; accepting requests continues.
- RB_15_0  out  16  registered write data bus to register blocks.
- WR_15_0  out  16  registered one-hot write strobes; bit n enables register n.
- RADDR  in  4  operand read address for forwarding lookup.
- BYP_HIT  out  1  combinational: a pending write to RADDR exists.
- BYP_DATA  out  16  combinational: data of youngest pending write to RADDR; 0 when no hit.
- PEND  out  1  any write pending (FIFO non-empty or WR_15_0 ≠ 0).

## Operation
- State: FIFO storage DEPTH×{4-bit addr, 16-bit data}, write pointer, read pointer, occupancy count (0..DEPTH), output stage (RB_15_0, WR_15_0).
- Push: on an edge with WREQ & READY, store {WADDR, WDATA} at the write pointer and increment it modulo DEPTH.
- READY = (count < DEPTH). When the FIFO is full, READY is 0 even if a pop occurs in the same cycle; there is no push-on-pop when full.
- Pop: on an edge with count > 0 and HOLD = 0:
  - the head moves to the output stage, with RB_15_0 ← data and WR_15_0 ← one-hot(addr);
  - the read pointer advances modulo DEPTH.
- Otherwise, on that edge WR_15_0 ← 0 and RB_15_0 holds its previous value.
- Simultaneous push and pop (count < DEPTH): both occur; count is unchanged.
- Writes drain strictly in acceptance order. Back-to-back writes to the same register are never merged; each produces its own strobe.
- Forwarding candidates are the output stage (only when WR_15_0 ≠ 0) and all valid FIFO entries. The youngest matching entry wins. Its age order is:
  - FIFO entries newest first;
  - then the output stage.
- The forwarding lookup is purely combinational on RADDR and current state. It does not depend on WREQ in the current cycle.
- Address/width: WADDR is fully decoded; no illegal values. Data passes through unmodified at 16 bits.

## Timing
- Reset values (asynchronous, immediate): count 0, both pointers 0, WR_15_0 = 0, RB_15_0 = 0. Consequently READY = 1, PEND = 0, BYP_HIT = 0, BYP_DATA = 0.
- RESET asserted mid-operation discards all pending writes. No partial strobe survives; WR_15_0 drops asynchronously.
- Latency, with a request accepted at edge E, FIFO empty and HOLD = 0:
  - the entry pops at E+1;
  - WR_15_0/RB_15_0 are valid from E+1 to E+2;
  - the register block captures at E+2.
- Throughput: one write per cycle sustained. With DEPTH = 2 and continuous WREQ, READY never drops while HOLD = 0.
- HOLD = 1 at edge E: no pop at E, and WR_15_0 is 0 after E. Pending data stays visible through BYP_*.
- FIFO full plus HOLD: READY stays 0 until the first edge with HOLD = 0 pops an entry. READY rises combinationally after that edge.
- Each WR_15_0 bit is high for exactly one cycle per drained entry. At most one bit is ever set.

## Test plan
- Reset then single write (WADDR = 5, WDATA = 0xA5C3) at edge 1:
  - WR_15_0 = 0x0020 and RB_15_0 = 0xA5C3 for exactly cycle 2–3;
  - PEND = 1 from edge 1 until edge 3.
- HOLD = 1 with three consecutive WREQs (r1 = 0x1111, r2 = 0x2222, r3 = 0x3333):
  - first two are accepted and READY = 0 after the second;
  - r3 stalls until HOLD drops;
  - strobes then appear in order 0x0002, 0x0004, 0x0008 on consecutive cycles.
- Forwarding with pending r7 = 0x1234 then r7 = 0xBEEF, and RADDR = 7: BYP_HIT = 1 and BYP_DATA = 0xBEEF. With RADDR = 6: BYP_HIT = 0 and BYP_DATA = 0.
- Continuous WREQ for 20 cycles, addresses 0..15 wrapping, HOLD = 0:
  - READY stays 1 throughout;
  - 20 strobes are emitted in order, each one-hot, with pointers wrapping correctly.
- RESET pulse while the FIFO is full and a strobe is active: WR_15_0 = 0 immediately, READY = 1, PEND = 0, and no strobe follows after release.
